// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
// Bundles the signals between the memory stage, the data-memory response
// path, the register-file write port and the id_stage hazard/bypass inputs.
//   slave  : used by wb_stage (consumes mem/dmem inputs, drives wb outputs)
//   master : used by the producer side / testbench
// Ports carried:
//   mem_valid_i, mem_ready_o            handshake with the memory stage
//   mem_rd_addr_i, mem_rd_we_i          destination register and its enable
//   mem_is_load_i, mem_load_size_i,     load descriptor
//   mem_load_unsigned_i, mem_addr_lo_i
//   mem_alu_result_i                    result for non-loads
//   dmem_rsp_valid_i/data_i/err_i       data-memory response
//   wb_reg_we_o/waddr_o/wdata_o         register-file write port
//   wb_load_err_o                       load error / timeout pulse
//   wb_load_pending_o, wb_load_rd_o     hazard info for id_stage
//   wb_fwd_valid_o/addr_o/data_o        bypass info (only with WB_FWD_EN)
// ---------------------------------------------------------------------------
interface wb_stage_if;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_rd_we_i;
  logic        mem_is_load_i;
  logic [1:0]  mem_load_size_i;
  logic        mem_load_unsigned_i;
  logic [1:0]  mem_addr_lo_i;
  logic [31:0] mem_alu_result_i;
  logic        dmem_rsp_valid_i;
  logic [31:0] dmem_rsp_data_i;
  logic        dmem_rsp_err_i;
  logic [31:0] wb_reg_wdata_o;
  logic [4:0]  wb_reg_waddr_o;
  logic        wb_reg_we_o;
  logic        wb_load_err_o;
  logic        wb_load_pending_o;
  logic [4:0]  wb_load_rd_o;
`ifdef WB_FWD_EN
  logic        wb_fwd_valid_o;
  logic [4:0]  wb_fwd_addr_o;
  logic [31:0] wb_fwd_data_o;
`endif

  modport slave (
    input  mem_valid_i, mem_rd_addr_i, mem_rd_we_i, mem_is_load_i,
           mem_load_size_i, mem_load_unsigned_i, mem_addr_lo_i,
           mem_alu_result_i, dmem_rsp_valid_i, dmem_rsp_data_i,
           dmem_rsp_err_i,
`ifdef WB_FWD_EN
    output wb_fwd_valid_o, wb_fwd_addr_o, wb_fwd_data_o,
`endif
    output mem_ready_o, wb_reg_wdata_o, wb_reg_waddr_o, wb_reg_we_o,
           wb_load_err_o, wb_load_pending_o, wb_load_rd_o
  );

  modport master (
    output mem_valid_i, mem_rd_addr_i, mem_rd_we_i, mem_is_load_i,
           mem_load_size_i, mem_load_unsigned_i, mem_addr_lo_i,
           mem_alu_result_i, dmem_rsp_valid_i, dmem_rsp_data_i,
           dmem_rsp_err_i,
`ifdef WB_FWD_EN
    input  wb_fwd_valid_o, wb_fwd_addr_o, wb_fwd_data_o,
`endif
    input  mem_ready_o, wb_reg_wdata_o, wb_reg_waddr_o, wb_reg_we_o,
           wb_load_err_o, wb_load_pending_o, wb_load_rd_o
  );
endinterface

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Writeback stage. Accepts ALU results and loads from the memory stage,
// waits for the data-memory response on loads, extracts/extends the load
// data and issues one registered register-file write per retired
// instruction. Exports load-pending hazard info for id_stage.
// Parameters:
//   RSP_TIMEOUT : max WAIT_RSP cycles before a load is aborted (0 = never)
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : wb_stage_if.slave (memory-stage handshake, dmem response,
//           register write port, hazard and optional bypass outputs)
// Optional feature macro: WB_FWD_EN adds the bypass outputs, which mirror
// the register write port so id_stage can forward the not-yet-committed
// value.
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   bus
);

  // Counter only has to represent 0 .. RSP_TIMEOUT-1.
  localparam int unsigned CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam bit TMO_EN = (RSP_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((RSP_TIMEOUT == 0) ? 0 : RSP_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT_RSP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       rd_reg, rd_next;
  logic             rd_we_reg, rd_we_next;
  logic [1:0]       size_reg, size_next;
  logic             uns_reg, uns_next;
  logic [1:0]       alo_reg, alo_next;
  logic             we_reg, we_next;
  logic [4:0]       waddr_reg, waddr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic             err_reg, err_next;
  logic             pend_reg, pend_next;

  // Load data extraction from the aligned response word.
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = bus.dmem_rsp_data_i[8*gi +: 8];
  end

  always_comb begin
    byte_sel  = lane[alo_reg];
    half_sel  = alo_reg[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
    load_data = bus.dmem_rsp_data_i;
    case (size_reg)
      2'b00:   load_data = {{24{~uns_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~uns_reg & half_sel[15]}}, half_sel};
      default: load_data = bus.dmem_rsp_data_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      rd_reg    <= '0;
      rd_we_reg <= 1'b0;
      size_reg  <= '0;
      uns_reg   <= 1'b0;
      alo_reg   <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rd_reg    <= rd_next;
      rd_we_reg <= rd_we_next;
      size_reg  <= size_next;
      uns_reg   <= uns_next;
      alo_reg   <= alo_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_next    = rd_reg;
    rd_we_next = rd_we_reg;
    size_next  = size_reg;
    uns_next   = uns_reg;
    alo_next   = alo_reg;
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Responses arriving here are stale and simply not looked at.
        if (bus.mem_valid_i) begin
          rd_next    = bus.mem_rd_addr_i;
          rd_we_next = bus.mem_rd_we_i;
          if (bus.mem_is_load_i) begin
            size_next  = bus.mem_load_size_i;
            uns_next   = bus.mem_load_unsigned_i;
            alo_next   = bus.mem_addr_lo_i;
            cnt_next   = '0;
            state_next = S_WAIT_RSP;
          end else if (bus.mem_rd_we_i && (bus.mem_rd_addr_i != 5'd0)) begin
            we_next    = 1'b1;
            waddr_next = bus.mem_rd_addr_i;
            wdata_next = bus.mem_alu_result_i;
          end
        end
      end
      S_WAIT_RSP: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // A response in the last allowed cycle takes priority over timeout.
        if (bus.dmem_rsp_valid_i) begin
          state_next = S_IDLE;
          if (bus.dmem_rsp_err_i) begin
            err_next = 1'b1;
          end else if (rd_we_reg && (rd_reg != 5'd0)) begin
            we_next    = 1'b1;
            waddr_next = rd_reg;
            wdata_next = load_data;
          end
        end else if (TMO_EN && (cnt_reg == TMO_LAST)) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pending flag is registered alongside the state it mirrors.
  assign pend_next             = (state_next == S_WAIT_RSP);
  assign bus.mem_ready_o       = (state_reg == S_IDLE);
  assign bus.wb_reg_we_o       = we_reg;
  assign bus.wb_reg_waddr_o    = waddr_reg;
  assign bus.wb_reg_wdata_o    = wdata_reg;
  assign bus.wb_load_err_o     = err_reg;
  assign bus.wb_load_pending_o = pend_reg;
  assign bus.wb_load_rd_o      = pend_reg ? rd_reg : 5'd0;

`ifdef WB_FWD_EN
  assign bus.wb_fwd_valid_o = we_reg;
  assign bus.wb_fwd_addr_o  = waddr_reg;
  assign bus.wb_fwd_data_o  = wdata_reg;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage (RSP_TIMEOUT=4). Expected outputs come
// from a per-cycle timeline filled in by the driver as each instruction is
// issued: the retire cycle, pending window and write contents are computed
// directly from the stage's rules. A negedge process compares every output
// against that timeline each cycle. Directed cases add literal checks.
// ---------------------------------------------------------------------------
module tb_wb_stage;
  localparam int T    = 4;
  localparam int MAXC = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  wb_stage_if bus ();
  wb_stage #(.RSP_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number.
  bit          exp_we   [MAXC];
  logic [4:0]  exp_waddr[MAXC];
  logic [31:0] exp_wdata[MAXC];
  bit          exp_err  [MAXC];
  bit          exp_pend [MAXC];
  logic [4:0]  exp_rd   [MAXC];
  // Log of observed outputs for directed literal checks.
  bit          act_we   [MAXC];
  logic [4:0]  act_waddr[MAXC];
  logic [31:0] act_wdata[MAXC];
  bit          act_err  [MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Load result from the architectural rule: take the addressed field,
  // then sign- or zero-extend it with plain arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] w, input int size,
                                             input bit uns, input int alo);
    longint v;
    int     nbits;
    int     sh;
    if (size == 0) begin
      sh = 8 * alo; nbits = 8;
    end else if (size == 1) begin
      sh = (alo >= 2) ? 16 : 0; nbits = 16;
    end else begin
      return w;
    end
    v = longint'(w >> sh) % (longint'(1) << nbits);
    if (!uns && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    return v[31:0];
  endfunction

  // Per-cycle compare against the timeline.
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;
  always @(negedge clk) begin
    int c;
    c = cyc;
    act_we[c]    = bus.wb_reg_we_o;
    act_waddr[c] = bus.wb_reg_waddr_o;
    act_wdata[c] = bus.wb_reg_wdata_o;
    act_err[c]   = bus.wb_load_err_o;
    if (!rst_n) begin
      hold_addr = '0;
      hold_data = '0;
      check("rst_we", bus.wb_reg_we_o, 0);
      check("rst_waddr", bus.wb_reg_waddr_o, 0);
      check("rst_wdata", bus.wb_reg_wdata_o, 0);
      check("rst_err", bus.wb_load_err_o, 0);
      check("rst_pend", bus.wb_load_pending_o, 0);
      check("rst_rd", bus.wb_load_rd_o, 0);
      check("rst_ready", bus.mem_ready_o, 1);
    end else begin
      if (exp_we[c]) begin
        hold_addr = exp_waddr[c];
        hold_data = exp_wdata[c];
      end
      check("we", bus.wb_reg_we_o, exp_we[c]);
      check("waddr", bus.wb_reg_waddr_o, hold_addr);
      check("wdata", bus.wb_reg_wdata_o, hold_data);
      check("err", bus.wb_load_err_o, exp_err[c]);
      check("pend", bus.wb_load_pending_o, exp_pend[c]);
      check("load_rd", bus.wb_load_rd_o, exp_pend[c] ? exp_rd[c] : 5'd0);
      check("ready", bus.mem_ready_o, !exp_pend[c]);
    end
`ifdef WB_FWD_EN
    check("fwd_valid", bus.wb_fwd_valid_o, bus.wb_reg_we_o);
    check("fwd_addr", bus.wb_fwd_addr_o, bus.wb_reg_waddr_o);
    check("fwd_data", bus.wb_fwd_data_o, bus.wb_reg_wdata_o);
`endif
  end

  task automatic go_next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    while (cyc <= k) go_next();
  endtask

  // Deassert valid, scramble don't-care fields; optionally strobe a stale
  // response (only used while the stage is idle).
  task automatic idle_inputs(input bit junk);
    bus.mem_valid_i         = 1'b0;
    bus.mem_rd_addr_i       = 5'($urandom);
    bus.mem_rd_we_i         = 1'($urandom);
    bus.mem_is_load_i       = 1'($urandom);
    bus.mem_load_size_i     = 2'($urandom);
    bus.mem_load_unsigned_i = 1'($urandom);
    bus.mem_addr_lo_i       = 2'($urandom);
    bus.mem_alu_result_i    = $urandom;
    bus.dmem_rsp_valid_i    = junk && ($urandom % 3 == 0);
    bus.dmem_rsp_data_i     = $urandom;
    bus.dmem_rsp_err_i      = 1'($urandom);
  endtask

  // Issue one instruction in the current (idle) cycle and, for loads, drive
  // the response d cycles into the wait. Returns the retire cycle.
  task automatic do_op(input bit is_load, input logic [4:0] rd, input bit we,
                       input logic [1:0] size, input bit uns, input logic [1:0] alo,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input bit rerr, input int d, output int ocyc);
    int c;
    int wcyc;
    c = cyc;
    idle_inputs(1'b1);
    bus.mem_valid_i         = 1'b1;
    bus.mem_rd_addr_i       = rd;
    bus.mem_rd_we_i         = we;
    bus.mem_is_load_i       = is_load;
    bus.mem_load_size_i     = size;
    bus.mem_load_unsigned_i = uns;
    bus.mem_addr_lo_i       = alo;
    bus.mem_alu_result_i    = alu;
    if (!is_load) begin
      ocyc = c + 1;
      if (we && rd != 0) begin
        exp_we[ocyc] = 1'b1; exp_waddr[ocyc] = rd; exp_wdata[ocyc] = alu;
      end
      $display("[%0d] ALU  rd=%0d we=%0b res=%h", c, rd, we, alu);
      go_next();
      idle_inputs(1'b1);
    end else begin
      wcyc = (d <= T) ? d : T;
      ocyc = c + wcyc + 1;
      for (int k = 1; k <= wcyc; k++) begin
        exp_pend[c + k] = 1'b1;
        exp_rd[c + k]   = rd;
      end
      if (d > T || rerr) begin
        exp_err[ocyc] = 1'b1;
      end else if (we && rd != 0) begin
        exp_we[ocyc]    = 1'b1;
        exp_waddr[ocyc] = rd;
        exp_wdata[ocyc] = model_load(rdata, int'(size), uns, int'(alo));
      end
      $display("[%0d] LOAD rd=%0d we=%0b size=%0d uns=%0b alo=%0d data=%h err=%0b lat=%0d",
               c, rd, we, size, uns, alo, rdata, rerr, d);
      go_next();
      idle_inputs(1'b0);
      for (int k = 1; k <= d; k++) begin
        if (k == d) begin
          bus.dmem_rsp_valid_i = 1'b1;
          bus.dmem_rsp_data_i  = rdata;
          bus.dmem_rsp_err_i   = rerr;
        end
        go_next();
        idle_inputs(1'b0);
      end
    end
  endtask

  task automatic lit(input string name, input int ocyc, input bit expw, input logic [31:0] expd);
    wait_until(ocyc);
    check({name, "_we"}, act_we[ocyc], expw);
    if (expw) check({name, "_data"}, act_wdata[ocyc], expd);
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int o1, o2, c;
    idle_inputs(1'b0);
    rst_n = 1'b0;
    repeat (3) go_next();
    rst_n = 1'b1;
    go_next();

    // Model pins.
    check("pin_sbyte", model_load(32'h80123456, 0, 1'b0, 3), 32'hFFFFFF80);
    check("pin_ubyte", model_load(32'h80123456, 0, 1'b1, 3), 32'h00000080);
    check("pin_shalf", model_load(32'h80011234, 1, 1'b0, 2), 32'hFFFF8001);
    check("pin_uhalf", model_load(32'h80011234, 1, 1'b1, 0), 32'h00001234);

    // Back-to-back ALU writes.
    do_op(1'b0, 5'd5, 1'b1, 2'd0, 1'b0, 2'd0, 32'hDEADBEEF, 0, 1'b0, 0, o1);
    do_op(1'b0, 5'd6, 1'b1, 2'd0, 1'b0, 2'd0, 32'h00000001, 0, 1'b0, 0, o2);
    lit("alu5", o1, 1'b1, 32'hDEADBEEF);
    check("alu5_addr", act_waddr[o1], 5);
    lit("alu6", o2, 1'b1, 32'h00000001);
    check("alu6_addr", act_waddr[o2], 6);
    check("alu_consec", o2 - o1, 1);

    // Load extraction cases.
    do_op(1'b1, 5'd7, 1'b1, 2'd0, 1'b0, 2'd3, 0, 32'h80123456, 1'b0, 2, o1);
    lit("ld_sb", o1, 1'b1, 32'hFFFFFF80);
    do_op(1'b1, 5'd7, 1'b1, 2'd0, 1'b1, 2'd3, 0, 32'h80123456, 1'b0, 1, o1);
    lit("ld_ub", o1, 1'b1, 32'h00000080);
    do_op(1'b1, 5'd8, 1'b1, 2'd1, 1'b0, 2'd2, 0, 32'h80011234, 1'b0, 3, o1);
    lit("ld_sh", o1, 1'b1, 32'hFFFF8001);
    do_op(1'b1, 5'd8, 1'b1, 2'd1, 1'b1, 2'd0, 0, 32'h80011234, 1'b0, 1, o1);
    lit("ld_uh", o1, 1'b1, 32'h00001234);
    do_op(1'b1, 5'd9, 1'b1, 2'd3, 1'b0, 2'd1, 0, 32'hCAFEF00D, 1'b0, 2, o1);
    lit("ld_w", o1, 1'b1, 32'hCAFEF00D);

    // No write for rd=0 or rd_we=0.
    do_op(1'b1, 5'd0, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'h11112222, 1'b0, 2, o1);
    lit("ld_rd0", o1, 1'b0, 0);
    do_op(1'b1, 5'd3, 1'b0, 2'd2, 1'b0, 2'd0, 0, 32'h33334444, 1'b0, 2, o1);
    lit("ld_nowe", o1, 1'b0, 0);

    // Timeout after exactly T wait cycles, late response ignored.
    c = cyc;
    do_op(1'b1, 5'd10, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'h55556666, 1'b0, 9, o1);
    wait_until(c + 10);
    check("tmo_err", act_err[c + T + 1], 1);
    check("tmo_early", act_err[c + T], 0);
    check("tmo_nowe", act_we[c + T + 1], 0);
    check("tmo_late_nowe", act_we[c + 10], 0);

    // Response in the last allowed cycle wins over the timeout.
    do_op(1'b1, 5'd11, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'h77778888, 1'b0, T, o1);
    lit("rsp_wins", o1, 1'b1, 32'h77778888);
    check("rsp_wins_err", act_err[o1], 0);

    // Error response.
    do_op(1'b1, 5'd12, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'h9999AAAA, 1'b1, 2, o1);
    lit("errrsp", o1, 1'b0, 0);
    check("errrsp_err", act_err[o1], 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int gap;
      do_op(1'($urandom), 5'($urandom), ($urandom % 4) != 0, 2'($urandom),
            1'($urandom), 2'($urandom), $urandom, $urandom,
            ($urandom % 8) == 0, 1 + int'($urandom % 7), o1);
      gap = int'($urandom % 3);
      repeat (gap) go_next();
    end
    wait_until(cyc + 2);

    // Reset in the middle of a load; the later response must be dropped.
    c = cyc;
    idle_inputs(1'b0);
    bus.mem_valid_i = 1'b1; bus.mem_is_load_i = 1'b1;
    bus.mem_rd_addr_i = 5'd9; bus.mem_rd_we_i = 1'b1; bus.mem_load_size_i = 2'd2;
    exp_pend[c + 1] = 1'b1; exp_rd[c + 1] = 5'd9;
    $display("[%0d] LOAD rd=9 reset mid-wait", c);
    go_next();
    idle_inputs(1'b0);
    go_next();
    rst_n = 1'b0;
    go_next();
    go_next();
    rst_n = 1'b1;
    go_next();
    bus.dmem_rsp_valid_i = 1'b1; bus.dmem_rsp_data_i = 32'h12345678; bus.dmem_rsp_err_i = 1'b0;
    go_next();
    idle_inputs(1'b0);
    wait_until(c + 8);
    check("rstmid_we", act_we[c + 6], 0);
    check("rstmid_ready", bus.mem_ready_o, 1);
    check("rstmid_pend", bus.wb_load_pending_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage that drives the register file write port (`wb_reg_wdata/waddr/we`) from results handed over by the memory stage. It accepts ALU results and load instructions over a valid/ready handshake and waits for the data-memory response on loads. It extracts and sign/zero-extends load bytes and halves, then issues exactly one registered write per retired instruction. It also exports hazard and bypass information to id_stage.

## Interface
- `RSP_TIMEOUT`, default 255: maximum WAIT_RSP cycles before a load is aborted; 0 disables the timeout.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_valid_i` input 1: memory stage offers an instruction.
- `mem_ready_o` output 1: wb_stage accepts the offered instruction this cycle.
- `mem_rd_addr_i` input 5: destination register.
- `mem_rd_we_i` input 1: instruction writes rd.
- `mem_is_load_i` input 1: instruction is a load; result comes from dmem.
- `mem_load_size_i` input 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_load_unsigned_i` input 1: zero-extend instead of sign-extend.
- `mem_addr_lo_i` input 2: load address bits [1:0].
- `mem_alu_result_i` input 32: result for non-loads.
- `dmem_rsp_valid_i` input 1: load response strobe.
- `dmem_rsp_data_i` input 32: aligned 32-bit word containing the load data.
- `dmem_rsp_err_i` input 1: bus error, qualified by `dmem_rsp_valid_i`.
- `wb_reg_wdata_o` output 32: register write data.
- `wb_reg_waddr_o` output 5: register write address.
- `wb_reg_we_o` output 1: register write enable, one-cycle pulse.
- `wb_load_err_o` output 1: one-cycle pulse on load error or timeout.
- `wb_load_pending_o` output 1: a load is in WAIT_RSP.
- `wb_load_rd_o` output 5: rd of the pending load; 0 when none is pending.
- `wb_fwd_valid_o` output 1: bypass valid. Present only with `WB_FWD_EN`.
- `wb_fwd_addr_o` output 5: bypass address. Present only with `WB_FWD_EN`.
- `wb_fwd_data_o` output 32: bypass data. Present only with `WB_FWD_EN`.

## Operation

**States**
- IDLE: `mem_ready_o=1`.
  - On `mem_valid_i & !mem_is_load_i`, capture rd, we and ALU result. Stay in IDLE.
  - On `mem_valid_i & mem_is_load_i`, capture rd, we, size, unsigned and addr_lo, clear the timeout counter, and go to WAIT_RSP.
- WAIT_RSP: `mem_ready_o=0`, and the counter increments every cycle.
  - On `dmem_rsp_valid_i & !dmem_rsp_err_i`, the extracted data is written and the FSM returns to IDLE.
  - On `dmem_rsp_valid_i & dmem_rsp_err_i`, there is no write, `wb_load_err_o` pulses, and the FSM returns to IDLE.
  - When `RSP_TIMEOUT!=0` and the counter reaches `RSP_TIMEOUT` without a response, the result is the same as an error.

**Load extraction**
- Byte: lane `addr_lo`, i.e. bits `[8*addr_lo+7 : 8*addr_lo]`.
- Half: lane `addr_lo[1]`; `addr_lo[0]` is ignored.
- Word: `addr_lo` is ignored.
- Extension: bit 7 or bit 15 is replicated unless unsigned is set, in which case the upper bits are zero.

**Write rules**
- `wb_reg_we_o` is asserted only if captured `rd_we=1` and `rd!=0`.
- `wb_reg_waddr_o` and `wb_reg_wdata_o` update on every write and hold otherwise.

**Boundary conditions**
- A `dmem_rsp_valid_i` arriving in IDLE is ignored.
- A response in the same cycle the counter hits the timeout: the response wins.
- `wb_load_pending_o=1` and `wb_load_rd_o=rd` throughout WAIT_RSP, so id_stage stalls dependents.
- Reset mid-load: the FSM returns to IDLE, no write is issued, and the response is dropped.

## Timing
- Reset values:
  - `mem_ready_o=1` (IDLE).
  - `wb_reg_we_o=0`, `wb_reg_waddr_o=0`, `wb_reg_wdata_o=0`.
  - `wb_load_err_o=0`, `wb_load_pending_o=0`, `wb_load_rd_o=0`.
  - Forwarding outputs 0.
- Non-load: accepted at edge N, and `wb_reg_we_o` is high during cycle N+1. The register file commits at edge N+2. Throughput is 1 per cycle.
- Load: accepted at edge N, so `mem_ready_o=0` from cycle N+1. A response at edge M gives `wb_reg_we_o` high in cycle M+1 and `mem_ready_o=1` in cycle M+1.
- Error or timeout: `wb_load_err_o` is high in the cycle where the write would have been.
- All outputs are registered except `mem_ready_o`, which is decoded from the state, and `wb_load_rd_o`.

## Configuration
- Macro `WB_FWD_EN`.
- Defined: `wb_fwd_valid_o`, `wb_fwd_addr_o` and `wb_fwd_data_o` mirror `wb_reg_we_o`, `wb_reg_waddr_o` and `wb_reg_wdata_o` in the same cycle. This lets id_stage bypass the value the register file has not yet committed, because the register file reads asynchronously and writes at the clock edge.
- Undefined: the ports are absent, and id_stage must stall one cycle on a wb/id address match.

## Test plan
- ALU op rd=5 result 0xDEADBEEF, followed back-to-back by rd=6 result 0x1 -> `we` pulses in two consecutive cycles, writing x5=0xDEADBEEF then x6=0x1; `mem_ready_o` stays 1.
- Signed byte load with addr_lo=3 and rsp data 0x80123456 -> x7=0xFFFFFF80. The same load unsigned -> 0x00000080.
- Half load with addr_lo=2 and data 0x8001_1234: signed -> 0xFFFF8001. With addr_lo=0 unsigned -> 0x00001234.
- Load to rd=0, or with `rd_we=0`, and valid rsp -> no `we` pulse; the FSM returns to IDLE.
- `RSP_TIMEOUT=4` with no response -> `wb_load_err_o` pulses once after 4 cycles, no write. Separately, an err response -> err pulse, no write.
- Reset asserted in WAIT_RSP, then a response after release -> no write; `mem_ready_o=1` and `wb_load_pending_o=0`.
